lockstep_compare: RTL and testbench

//  Parametrised lockstep checker: compares a reference stream (A) against an implementation stream (B).
//  - Generalises the single-bit, same-cycle o1==o2 equivalence check to WIDTH-bit data with valid qualifiers.
//  - Adds a fixed A->B skew, a saturating mismatch counter, first-mismatch capture and an optional halt mode.
//  - Sits beside a DUT pair in the formal/sim top; its outputs feed assertions and cover points.

---
 rtl/lockstep_pkg.sv | 23 ++
 rtl/lockstep_compare_skew_delay.sv | 45 ++++
 rtl/lockstep_compare.sv | 157 +++++++++++++++
 tb/tb_lockstep_compare.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lockstep_pkg.sv
// Shared types and helpers for the lockstep stream checker.
package lockstep_pkg;

  // Checker FSM states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    CHECK = 2'd2,
    HALT  = 2'd3
  } state_e;

  // Largest supported A->B skew; the fill counter is sized for it
  localparam int SKEW_MAX = 15;
  localparam int FILL_W   = $clog2(SKEW_MAX + 1);

  // Saturating increment of the low w bits of v; never wraps past all-ones
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int w);
    logic [31:0] lim;
    lim = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    return (v >= lim) ? lim : (v + 32'd1);
  endfunction

endpackage

// File: rtl/lockstep_compare_skew_delay.sv
// Fixed-depth shift register for {valid,data}. The MSB of the word is the
// valid bit; flush drops every in-flight valid without disturbing data.
module skew_delay #(
  parameter int W     = 9,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         flush,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  generate
    if (DEPTH == 0) begin : g_wire
      // Zero skew: the delayed stream is the live stream
      logic unused_ctl;
      assign unused_ctl = ^{clk, rst, en, flush};
      assign q = d;
    end else begin : g_pipe
      logic [DEPTH-1:0][W-1:0] pipe_q, pipe_d;

      // Next stage contents: flush clears valids, otherwise shift when enabled
      always_comb begin
        pipe_d = pipe_q;
        if (flush) begin
          for (int i = 0; i < DEPTH; i++) pipe_d[i][W-1] = 1'b0;
        end else if (en) begin
          pipe_d[0] = d;
          for (int i = 1; i < DEPTH; i++) pipe_d[i] = pipe_q[i-1];
        end
      end

      // Stage registers, cleared on reset
      always_ff @(posedge clk) begin
        if (rst) pipe_q <= '0;
        else     pipe_q <= pipe_d;
      end

      assign q = pipe_q[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/lockstep_compare.sv
// Lockstep checker: delays reference stream A by SKEW cycles and compares it
// against implementation stream B, counting compares and mismatches and
// capturing the first failing pair. Optional halt on first failure.
module lockstep_compare
  import lockstep_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int SKEW         = 2,
  parameter int CNT_W        = 8,
  parameter int STOP_ON_FAIL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clear,
  input  logic             a_valid,
  input  logic [WIDTH-1:0] a_data,
  input  logic             b_valid,
  input  logic [WIDTH-1:0] b_data,
  output logic             mismatch,
  output logic             err_sticky,
  output logic [CNT_W-1:0] mis_cnt,
  output logic [CNT_W-1:0] cmp_idx,
  output logic [WIDTH-1:0] first_a,
  output logic [WIDTH-1:0] first_b,
  output logic [CNT_W-1:0] first_idx,
  output logic             halted
);

  state_e            state_q, state_d;
  logic [FILL_W-1:0] fill_q, fill_d;

  logic              mismatch_q, mismatch_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  mis_cnt_q, mis_cnt_d;
  logic [CNT_W-1:0]  cmp_idx_q, cmp_idx_d;
  logic [WIDTH-1:0]  first_a_q, first_a_d;
  logic [WIDTH-1:0]  first_b_q, first_b_d;
  logic [CNT_W-1:0]  first_idx_q, first_idx_d;

  logic [WIDTH:0]    dly_out;
  logic              da_valid;
  logic [WIDTH-1:0]  da_data;
  logic              do_cmp;
  logic              cmp_bad;

  // A is held back SKEW cycles; valids are dropped while idle so a restart
  // never compares stale samples
  skew_delay #(
    .W     (WIDTH + 1),
    .DEPTH (SKEW)
  ) u_dly (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .flush (state_q == IDLE),
    .d     ({a_valid, a_data}),
    .q     (dly_out)
  );

  assign da_valid = dly_out[WIDTH];
  assign da_data  = dly_out[WIDTH-1:0];

  // Compare point: a one-sided valid counts as a compare and a mismatch
  always_comb begin
    do_cmp  = 1'b0;
    cmp_bad = 1'b0;
    if (en && state_q == CHECK && (da_valid || b_valid)) begin
      do_cmp  = 1'b1;
      cmp_bad = (da_valid ^ b_valid) || (da_data != b_data);
    end
  end

  // Next-state: wait out the skew, then check; optionally park on failure
  always_comb begin
    state_d = state_q;
    fill_d  = fill_q;
    if (!en) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          fill_d = '0;
          if (SKEW == 0) state_d = CHECK;
          else           state_d = FILL;
        end
        FILL: begin
          if (fill_q == FILL_W'(SKEW - 1)) state_d = CHECK;
          else                             fill_d  = fill_q + 1'b1;
        end
        CHECK: begin
          if (STOP_ON_FAIL != 0 && cmp_bad) state_d = HALT;
        end
        HALT: begin
          if (clear) state_d = CHECK;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Counters and capture: clear wipes first, then this cycle's result lands
  always_comb begin
    mis_cnt_d   = clear ? '0 : mis_cnt_q;
    cmp_idx_d   = clear ? '0 : cmp_idx_q;
    err_d       = clear ? 1'b0 : err_q;
    first_a_d   = clear ? '0 : first_a_q;
    first_b_d   = clear ? '0 : first_b_q;
    first_idx_d = clear ? '0 : first_idx_q;
    mismatch_d  = cmp_bad;
    if (cmp_bad && !err_d) begin
      first_a_d   = da_valid ? da_data : '0;
      first_b_d   = b_valid ? b_data : '0;
      first_idx_d = cmp_idx_d;
    end
    if (cmp_bad) begin
      err_d     = 1'b1;
      mis_cnt_d = CNT_W'(sat_inc(32'(mis_cnt_d), CNT_W));
    end
    if (do_cmp) cmp_idx_d = CNT_W'(sat_inc(32'(cmp_idx_d), CNT_W));
  end

  // State and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      fill_q      <= '0;
      mismatch_q  <= 1'b0;
      err_q       <= 1'b0;
      mis_cnt_q   <= '0;
      cmp_idx_q   <= '0;
      first_a_q   <= '0;
      first_b_q   <= '0;
      first_idx_q <= '0;
    end else begin
      state_q     <= state_d;
      fill_q      <= fill_d;
      mismatch_q  <= mismatch_d;
      err_q       <= err_d;
      mis_cnt_q   <= mis_cnt_d;
      cmp_idx_q   <= cmp_idx_d;
      first_a_q   <= first_a_d;
      first_b_q   <= first_b_d;
      first_idx_q <= first_idx_d;
    end
  end

  assign mismatch   = mismatch_q;
  assign err_sticky = err_q;
  assign mis_cnt    = mis_cnt_q;
  assign cmp_idx    = cmp_idx_q;
  assign first_a    = first_a_q;
  assign first_b    = first_b_q;
  assign first_idx  = first_idx_q;
  assign halted     = (state_q == HALT);

endmodule

// File: tb/tb_lockstep_compare.sv
// Bench for lockstep_compare: four configurations share one stimulus stream
// (SKEW=2, SKEW=0, CNT_W=4, STOP_ON_FAIL=1). Vectors are built into a table,
// expectations queued as each vector is driven and checked one cycle later.
module tb_lockstep_compare;

  localparam int STOP2 = 0;
  localparam int STOPH = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, en, clear;
  logic       a_valid, b_valid, b0_valid;
  logic [7:0] a_data, b_data, b0_data;

  logic mis2, st2, h2;  logic [7:0] mc2, ci2, fa2, fb2, fi2;
  logic mis0, st0, h0;  logic [7:0] mc0, ci0, fa0, fb0, fi0;
  logic mis4, st4, h4;  logic [3:0] mc4, ci4, fi4; logic [7:0] fa4, fb4;
  logic mish, sth, hh;  logic [7:0] mch, cih, fah, fbh, fih;

  lockstep_compare #(.WIDTH(8), .SKEW(2), .CNT_W(8), .STOP_ON_FAIL(STOP2)) u2 (
    .clk(clk), .rst(rst), .en(en), .clear(clear),
    .a_valid(a_valid), .a_data(a_data), .b_valid(b_valid), .b_data(b_data),
    .mismatch(mis2), .err_sticky(st2), .mis_cnt(mc2), .cmp_idx(ci2),
    .first_a(fa2), .first_b(fb2), .first_idx(fi2), .halted(h2));

  lockstep_compare #(.WIDTH(8), .SKEW(0), .CNT_W(8), .STOP_ON_FAIL(0)) u0 (
    .clk(clk), .rst(rst), .en(en), .clear(clear),
    .a_valid(a_valid), .a_data(a_data), .b_valid(b0_valid), .b_data(b0_data),
    .mismatch(mis0), .err_sticky(st0), .mis_cnt(mc0), .cmp_idx(ci0),
    .first_a(fa0), .first_b(fb0), .first_idx(fi0), .halted(h0));

  lockstep_compare #(.WIDTH(8), .SKEW(2), .CNT_W(4), .STOP_ON_FAIL(0)) u4 (
    .clk(clk), .rst(rst), .en(en), .clear(clear),
    .a_valid(a_valid), .a_data(a_data), .b_valid(b_valid), .b_data(b_data),
    .mismatch(mis4), .err_sticky(st4), .mis_cnt(mc4), .cmp_idx(ci4),
    .first_a(fa4), .first_b(fb4), .first_idx(fi4), .halted(h4));

  lockstep_compare #(.WIDTH(8), .SKEW(2), .CNT_W(8), .STOP_ON_FAIL(STOPH)) uh (
    .clk(clk), .rst(rst), .en(en), .clear(clear),
    .a_valid(a_valid), .a_data(a_data), .b_valid(b_valid), .b_data(b_data),
    .mismatch(mish), .err_sticky(sth), .mis_cnt(mch), .cmp_idx(cih),
    .first_a(fah), .first_b(fbh), .first_idx(fih), .halted(hh));

  // A reported mismatch always comes with the sticky flag; only a halting
  // instance may ever sit in HALT
  a_st2: assert property (@(posedge clk) disable iff (rst) mis2 |-> st2);
  a_st0: assert property (@(posedge clk) disable iff (rst) mis0 |-> st0);
  a_st4: assert property (@(posedge clk) disable iff (rst) mis4 |-> st4);
  a_sth: assert property (@(posedge clk) disable iff (rst) mish |-> sth);
  a_h2:  assert property (@(posedge clk) disable iff (rst) h2 |-> (STOP2 != 0));
  a_hh:  assert property (@(posedge clk) disable iff (rst) hh |-> (STOPH != 0));

  typedef struct {
    bit av; logic [7:0] ad;
    bit bv; logic [7:0] bd;
    bit b0v; logic [7:0] b0d;
    bit clr;
    bit c2, m2; logic [7:0] da2, bx2;
    bit c0, m0; logic [7:0] da0, bx0;
  } vec_t;

  typedef struct { int mis; int idx; int fa; int fb; int fi; int mx; bit st; } mdl_t;

  vec_t vecs[$];
  vec_t sb[$];
  mdl_t md2, md0, md4;
  int   total = 0;
  int   bad   = 0;

  function automatic logic [7:0] pat(input int i);
    return 8'(i + 32'h35);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic void mreset();
    md2 = '{default:0}; md2.mx = 255;
    md0 = '{default:0}; md0.mx = 255;
    md4 = '{default:0}; md4.mx = 15;
  endfunction

  // Expected counter/capture behaviour for one instance
  function automatic void apply(inout mdl_t m, input bit clr, input bit c, input bit mm,
                                input logic [7:0] da, input logic [7:0] bx);
    if (clr) begin m.mis = 0; m.idx = 0; m.st = 0; m.fa = 0; m.fb = 0; m.fi = 0; end
    if (mm && !m.st) begin m.fa = da; m.fb = bx; m.fi = m.idx; end
    if (mm) begin m.st = 1; if (m.mis < m.mx) m.mis++; end
    if (c && m.idx < m.mx) m.idx++;
  endfunction

  // Build a stream of n A samples (k=1..n). B for SKEW=2 is A two cycles
  // later (compare #j at k=j+2); B for SKEW=0 is A same cycle. noisy adds
  // valid junk during IDLE/FILL that must never be compared.
  function automatic void build(input int n, input int bad1, input int bad2, input bit allbad,
                                input int drop0, input bit noisy, input int clr_k);
    vec_t v; bit dav; logic [7:0] dad;
    vecs.delete();
    for (int k = 0; k <= n + 2; k++) begin
      v = '{default:0};
      v.av = (k >= 1 && k <= n) || (noisy && k == 0);
      v.ad = v.av ? pat(k) : 8'h00;
      v.bv = (k >= 3 && k <= n + 2) || (noisy && k < 3);
      if (k >= 3 && k <= n + 2) begin
        v.bd = pat(k - 2);
        if (allbad || k - 2 == bad1 || k - 2 == bad2) v.bd ^= 8'h01;
      end else if (v.bv) v.bd = 8'hFF;
      v.b0v = v.av && (k != drop0);
      v.b0d = v.b0v ? v.ad : 8'h00;
      v.clr = (k == clr_k);
      dav   = (k >= 2) ? vecs[k-2].av : 1'b0;
      dad   = (k >= 2) ? vecs[k-2].ad : 8'h00;
      v.c2  = (k >= 3) && (dav || v.bv);
      v.m2  = v.c2 && (dav != v.bv || dad != v.bd);
      v.da2 = dav ? dad : 8'h00;
      v.bx2 = v.bv ? v.bd : 8'h00;
      v.c0  = (k >= 1) && (v.av || v.b0v);
      v.m0  = v.c0 && (v.av != v.b0v || v.ad != v.b0d);
      v.da0 = v.ad;
      v.bx0 = v.b0d;
      vecs.push_back(v);
    end
  endfunction

  task automatic run(input int lo, input int hi);
    vec_t e;
    for (int k = lo; k <= hi; k++) begin
      en = 1'b1; clear = vecs[k].clr;
      a_valid  = vecs[k].av;  a_data  = vecs[k].ad;
      b_valid  = vecs[k].bv;  b_data  = vecs[k].bd;
      b0_valid = vecs[k].b0v; b0_data = vecs[k].b0d;
      sb.push_back(vecs[k]);
      @(posedge clk); #1;
      e = sb.pop_front();
      apply(md2, e.clr, e.c2, e.m2, e.da2, e.bx2);
      apply(md4, e.clr, e.c2, e.m2, e.da2, e.bx2);
      apply(md0, e.clr, e.c0, e.m0, e.da0, e.bx0);
      chk("u2.mismatch",  mis2, e.m2);
      chk("u2.mis_cnt",   mc2, md2.mis);
      chk("u2.cmp_idx",   ci2, md2.idx);
      chk("u2.sticky",    st2, md2.st);
      chk("u2.first_a",   fa2, md2.fa);
      chk("u2.first_b",   fb2, md2.fb);
      chk("u2.first_idx", fi2, md2.fi);
      chk("u0.mismatch",  mis0, e.m0);
      chk("u0.mis_cnt",   mc0, md0.mis);
      chk("u0.cmp_idx",   ci0, md0.idx);
      chk("u4.mismatch",  mis4, e.m2);
      chk("u4.mis_cnt",   mc4, md4.mis);
      chk("u4.cmp_idx",   ci4, md4.idx);
    end
    clear = 1'b0;
  endtask

  task automatic quiet();
    a_valid = 0; a_data = 0; b_valid = 0; b_data = 0; b0_valid = 0; b0_data = 0;
  endtask

  task automatic reset_dut();
    rst = 1; en = 0; clear = 0; quiet();
    @(posedge clk); #1;
    rst = 0; mreset();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " mismatch"}, mis2, 0);
    chk({tag, " sticky"},   st2, 0);
    chk({tag, " mis_cnt"},  mc2, 0);
    chk({tag, " cmp_idx"},  ci2, 0);
    chk({tag, " first_a"},  fa2, 0);
    chk({tag, " first_b"},  fb2, 0);
    chk({tag, " first_idx"}, fi2, 0);
    chk({tag, " halted"},   h2, 0);
  endtask

  initial begin
    rst = 1; en = 0; clear = 0; quiet();
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    chk("reset u0.halted", h0, 0);
    chk("reset uh.halted", hh, 0);
    rst = 0; mreset();

    // Clean SKEW=2 stream; SKEW=0 side drops b_valid once at k=10
    build(50, 0, 0, 0, 10, 0, -1);
    run(0, 52);
    chk("clean cmp_idx",      ci2, 50);
    chk("clean sticky",       st2, 0);
    chk("clean mis_cnt",      mc2, 0);
    chk("drop mis_cnt",       mc0, 1);
    chk("drop first_b",       fb0, 0);
    chk("drop first_a",       fa0, pat(10));
    chk("drop first_idx",     fi0, 9);
    chk("drop sticky",        st0, 1);
    chk("cnt4 cmp_idx sat",   ci4, 15);
    chk("cnt4 sticky",        st4, 0);

    // Single corruption at compare #7
    reset_dut();
    build(10, 7, 0, 0, -1, 0, -1);
    run(0, 12);
    chk("bad7 first_a",   fa2, 8'h3C);
    chk("bad7 first_b",   fb2, 8'h3D);
    chk("bad7 first_idx", fi2, 6);
    chk("bad7 mis_cnt",   mc2, 1);
    chk("bad7 u4 first_a",   fa4, 8'h3C);
    chk("bad7 u4 first_b",   fb4, 8'h3D);
    chk("bad7 u4 first_idx", fi4, 6);

    // 20 mismatches: saturation on CNT_W=4, halt on STOP_ON_FAIL
    reset_dut();
    build(20, 0, 0, 1, -1, 0, -1);
    run(0, 22);
    chk("sat mis_cnt4",   mc4, 15);
    chk("sat cmp_idx4",   ci4, 15);
    chk("sat mis_cnt8",   mc2, 20);
    chk("halt halted",    hh, 1);
    chk("halt mis_cnt",   mch, 1);
    chk("halt cmp_idx",   cih, 1);
    chk("halt first_a",   fah, pat(1));
    chk("halt first_b",   fbh, pat(1) ^ 8'h01);
    chk("halt first_idx", fih, 0);
    chk("halt mismatch",  mish, 0);
    chk("halt sticky",    sth, 1);
    quiet(); clear = 1;
    @(posedge clk); #1;
    clear = 0;
    chk("unhalt halted",  hh, 0);
    chk("unhalt mis_cnt", mch, 0);
    chk("unhalt sticky",  sth, 0);

    // clear landing on the same cycle as a second mismatch
    reset_dut();
    build(12, 3, 9, 0, -1, 0, 11);
    run(0, 14);
    chk("clrmis mis_cnt",   mc2, 1);
    chk("clrmis sticky",    st2, 1);
    chk("clrmis first_a",   fa2, pat(9));
    chk("clrmis first_b",   fb2, pat(9) ^ 8'h01);
    chk("clrmis first_idx", fi2, 0);
    chk("clrmis cmp_idx",   ci2, 4);

    // Reset mid-check, then restart with junk during the fill window
    reset_dut();
    build(30, 0, 0, 0, -1, 0, -1);
    run(0, 12);
    rst = 1;
    @(posedge clk); #1;
    chk_zero("midrst");
    rst = 0; mreset();
    build(8, 2, 0, 0, -1, 1, -1);
    run(0, 10);
    chk("refill cmp_idx",   ci2, 8);
    chk("refill first_idx", fi2, 1);
    chk("refill mis_cnt",   mc2, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
